// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings, write-back select
// enums and the little-endian load extension helper.
package mips_pkg;

    localparam logic [5:0] SPECIAL = 6'h00;
    localparam logic [5:0] JAL     = 6'h03;
    localparam logic [5:0] ADDI    = 6'h08;
    localparam logic [5:0] ANDI    = 6'h0c;
    localparam logic [5:0] ORI     = 6'h0d;
    localparam logic [5:0] LUI     = 6'h0f;
    localparam logic [5:0] LB      = 6'h20;
    localparam logic [5:0] LH      = 6'h21;
    localparam logic [5:0] LW      = 6'h23;
    localparam logic [5:0] LBU     = 6'h24;
    localparam logic [5:0] LHU     = 6'h25;
    localparam logic [5:0] COND_OP = 6'h3f;

    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [2:0] {WB_NONE, WB_AO, WB_EXT, WB_LOAD, WB_PC8, WB_MDU} wbSel_t;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_31} dstSel_t;

    // Unaligned offsets are honoured as-is; halfwords ignore offs[0].
    function automatic logic [31:0] loadExtend(input logic [5:0] op,
                                               input logic [31:0] word,
                                               input logic [1:0] offs);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offs)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offs[1] ? word[31:16] : word[15:0];
        case (op)
            LB:      r = {{24{b[7]}}, b};
            LBU:     r = {24'd0, b};
            LH:      r = {{16{h[15]}}, h};
            LHU:     r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the M/W register, D-stage readers and hazard logic (master)
// and the write-back stage (slave).
interface wb_stage_if;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ext32;
    logic [31:0] ao;
    logic [31:0] mduo;
    logic [31:0] rd;
    logic        con;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic        tr_valid;
    logic [31:0] tr_pc;
    logic [4:0]  tr_reg;
    logic [31:0] tr_data;

    modport master (
        output instr, pc, ext32, ao, mduo, rd, con, ra1, ra2,
        input  rd1, rd2, w_wa, w_wd, tr_valid, tr_pc, tr_reg, tr_data
    );

    modport slave (
        input  instr, pc, ext32, ao, mduo, rd, con, ra1, ra2,
        output rd1, rd2, w_wa, w_wd, tr_valid, tr_pc, tr_reg, tr_data
    );
endinterface

// File: rtl/grf.sv
// 32x32 general register file: synchronous clear, one write port, two
// asynchronous read ports, no bypass.
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] r_mem [32];

    // Clear beats any write pending on the same edge; $0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = r_mem[i_ra1];
    assign o_rd2 = r_mem[i_ra2];
endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: decodes the W instruction, extends load data, picks
// the write-back value/destination, writes the GRF and bypasses W->D reads.
module wb_stage
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    wb_stage_if.slave bus
);
    wbSel_t      w_wbSel;
    dstSel_t     w_dstSel;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [31:0] w_loadData;
    logic [31:0] w_pc8;
    logic [31:0] w_data;
    logic [4:0]  w_dst;
    logic [4:0]  w_addr;
    logic        w_we;
    logic [31:0] w_grfRd1;
    logic [31:0] w_grfRd2;
    logic        w_unused;

    assign w_op     = bus.instr[31:26];
    assign w_funct  = bus.instr[5:0];
    assign w_pc8    = bus.pc + 32'd8;
    assign w_unused = ^{bus.instr[25:21], bus.instr[10:6]};

    always_comb begin
        w_wbSel  = WB_NONE;
        w_dstSel = DST_RD;
        case (w_op)
            SPECIAL: begin
                case (w_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: w_wbSel = WB_AO;
                    FN_JALR:          w_wbSel = WB_PC8;
                    FN_MFHI, FN_MFLO: w_wbSel = WB_MDU;
                    default:          w_wbSel = WB_NONE;
                endcase
            end
            ADDI, ANDI, ORI: begin
                w_wbSel  = WB_AO;
                w_dstSel = DST_RT;
            end
            LUI: begin
                w_wbSel  = WB_EXT;
                w_dstSel = DST_RT;
            end
            LW, LB, LBU, LH, LHU: begin
                w_wbSel  = WB_LOAD;
                w_dstSel = DST_RT;
            end
            JAL: begin
                w_wbSel  = WB_PC8;
                w_dstSel = DST_31;
            end
            COND_OP: begin
                w_wbSel  = bus.con ? WB_PC8 : WB_NONE;
                w_dstSel = DST_31;
            end
            default: begin
                w_wbSel  = WB_NONE;
                w_dstSel = DST_RD;
            end
        endcase
    end

    assign w_loadData = loadExtend(w_op, bus.rd, bus.ao[1:0]);

    // Non-writing classes drive zero data so an idle (reset) pipe shows 0/0.
    always_comb begin
        w_data = '0;
        case (w_wbSel)
            WB_AO:   w_data = bus.ao;
            WB_EXT:  w_data = bus.ext32;
            WB_LOAD: w_data = w_loadData;
            WB_PC8:  w_data = w_pc8;
            WB_MDU:  w_data = bus.mduo;
            default: w_data = '0;
        endcase
        w_dst = bus.instr[15:11];
        case (w_dstSel)
            DST_RT:  w_dst = bus.instr[20:16];
            DST_31:  w_dst = 5'd31;
            default: w_dst = bus.instr[15:11];
        endcase
    end

    assign w_addr = (w_wbSel == WB_NONE) ? 5'd0 : w_dst;
    assign w_we   = (w_addr != 5'd0) && !reset;

    grf u_grf (
        .clk   (clk),
        .reset (reset),
        .i_we  (w_we),
        .i_wa  (w_addr),
        .i_wd  (w_data),
        .i_ra1 (bus.ra1),
        .i_ra2 (bus.ra2),
        .o_rd1 (w_grfRd1),
        .o_rd2 (w_grfRd2)
    );

    // Same-cycle bypass: a reader of the register being written sees the new value.
    assign bus.rd1 = (bus.ra1 == 5'd0) ? 32'd0 :
                     (w_we && (bus.ra1 == w_addr)) ? w_data : w_grfRd1;
    assign bus.rd2 = (bus.ra2 == 5'd0) ? 32'd0 :
                     (w_we && (bus.ra2 == w_addr)) ? w_data : w_grfRd2;

    assign bus.w_wa     = w_addr;
    assign bus.w_wd     = w_data;
    assign bus.tr_valid = w_we;
    assign bus.tr_pc    = bus.pc;
    assign bus.tr_reg   = w_addr;
    assign bus.tr_data  = w_data;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// instructions, checked against a behavioural register-file model.
module tb_wb_stage;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] refGrf [32];
    logic [4:0]  expWa;
    logic [31:0] expWd;
    logic        expWe;

    wb_stage_if bus ();

    wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] encR(input logic [5:0] fn, input logic [4:0] rdf);
        return {6'h00, 5'd3, 5'd4, rdf, 5'd0, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd2, rt, 16'h1234};
    endfunction

    // Architectural meaning of each instruction class, written from the ISA rules
    function automatic void refWrite(input logic [31:0] ins, input logic [31:0] pcv,
                                     input logic [31:0] ext, input logic [31:0] aov,
                                     input logic [31:0] mdu, input logic [31:0] mem,
                                     input logic c, output logic [4:0] wa,
                                     output logic [31:0] wd);
        int          op;
        int          fn;
        logic [31:0] b;
        logic [31:0] h;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        b  = (mem >> (8 * aov[1:0])) & 32'hff;
        h  = (mem >> (16 * aov[1])) & 32'hffff;
        wa = 5'd0;
        wd = 32'd0;
        if (op == 0 && fn inside {32, 34, 36, 37, 42, 43}) begin
            wa = ins[15:11]; wd = aov;
        end else if (op == 0 && fn == 9) begin
            wa = ins[15:11]; wd = pcv + 8;
        end else if (op == 0 && (fn == 16 || fn == 18)) begin
            wa = ins[15:11]; wd = mdu;
        end else if (op inside {8, 12, 13}) begin
            wa = ins[20:16]; wd = aov;
        end else if (op == 15) begin
            wa = ins[20:16]; wd = ext;
        end else if (op == 35) begin
            wa = ins[20:16]; wd = mem;
        end else if (op == 32) begin
            wa = ins[20:16]; wd = b[7] ? (b | 32'hffffff00) : b;
        end else if (op == 36) begin
            wa = ins[20:16]; wd = b;
        end else if (op == 33) begin
            wa = ins[20:16]; wd = h[15] ? (h | 32'hffff0000) : h;
        end else if (op == 37) begin
            wa = ins[20:16]; wd = h;
        end else if (op == 3 || (op == 63 && c)) begin
            wa = 5'd31; wd = pcv + 8;
        end
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (expWe && ra == expWa) return expWd;
        return refGrf[ra];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one W-stage beat, then check combinational outputs at the falling edge
    task automatic applyStimulus(input logic rst, input logic [31:0] ins,
                                 input logic [31:0] pcv, input logic [31:0] ext,
                                 input logic [31:0] aov, input logic [31:0] mdu,
                                 input logic [31:0] mem, input logic c,
                                 input logic [4:0] a1, input logic [4:0] a2);
        reset     = rst;
        bus.instr = ins;
        bus.pc    = pcv;
        bus.ext32 = ext;
        bus.ao    = aov;
        bus.mduo  = mdu;
        bus.rd    = mem;
        bus.con   = c;
        bus.ra1   = a1;
        bus.ra2   = a2;
        refWrite(ins, pcv, ext, aov, mdu, mem, c, expWa, expWd);
        expWe = (expWa != 5'd0) && !rst;
        @(negedge clk);
        checkOutput("w_wa", {27'd0, bus.w_wa}, {27'd0, expWa});
        if (expWa != 5'd0) checkOutput("w_wd", bus.w_wd, expWd);
        checkOutput("tr_valid", {31'd0, bus.tr_valid}, {31'd0, expWe});
        checkOutput("tr_pc", bus.tr_pc, pcv);
        checkOutput("tr_reg", {27'd0, bus.tr_reg}, {27'd0, expWa});
        if (expWa != 5'd0) checkOutput("tr_data", bus.tr_data, expWd);
        checkOutput("rd1", bus.rd1, expRead(a1));
        checkOutput("rd2", bus.rd2, expRead(a2));
    endtask

    // Clock edge: the model commits exactly what the architecture says should commit
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) refGrf[i] = 32'd0;
        end else if (expWe) begin
            refGrf[expWa] = expWd;
        end
        #1;
    endtask

    // Directed sequence, then randomized instructions
    initial begin
        logic [5:0]  rOp;
        logic [31:0] rIns;
        logic [5:0]  aluFn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b};
        logic [5:0]  ldOp  [5] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
        logic [5:0]  iOp   [3] = '{6'h08, 6'h0c, 6'h0d};
        logic [5:0]  nwFn  [3] = '{6'h08, 6'h18, 6'h11};
        logic [4:0]  a1;
        logic [4:0]  a2;
        total = 0;
        bad   = 0;
        expWa = 5'd0;
        expWd = 32'd0;
        expWe = 1'b0;
        $display("[TB] wb_stage bench starting");
        reset = 1'b1;
        bus.instr = '0; bus.pc = '0; bus.ext32 = '0; bus.ao = '0;
        bus.mduo = '0; bus.rd = '0; bus.con = 1'b0; bus.ra1 = '0; bus.ra2 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) refGrf[i] = 32'd0;

        applyStimulus(1'b1, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd17);
        checkOutput("rst_wd", bus.w_wd, 32'd0);
        checkOutput("rst_rd1", bus.rd1, 32'd0);
        tick();

        applyStimulus(1'b0, encI(6'h0d, 5'd5), 32'h3000, 32'h0, 32'h1234, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        checkOutput("ori_tv", {31'd0, bus.tr_valid}, 32'd1);
        checkOutput("ori_reg", {27'd0, bus.tr_reg}, 32'd5);
        tick();
        applyStimulus(1'b0, 32'd0, 32'h3004, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd0);
        checkOutput("rd5", bus.rd1, 32'h00001234);
        checkOutput("rd0", bus.rd2, 32'd0);
        tick();

        applyStimulus(1'b0, encI(6'h20, 5'd10), 32'h3008, 32'h0, 32'h3, 32'h0, 32'h80FF7F01, 1'b0, 5'd0, 5'd0);
        checkOutput("lb3", bus.w_wd, 32'hFFFFFF80);
        tick();
        applyStimulus(1'b0, encI(6'h24, 5'd11), 32'h300c, 32'h0, 32'h3, 32'h0, 32'h80FF7F01, 1'b0, 5'd10, 5'd0);
        checkOutput("lbu3", bus.w_wd, 32'h00000080);
        tick();
        applyStimulus(1'b0, encI(6'h21, 5'd12), 32'h3010, 32'h0, 32'h2, 32'h0, 32'h80FF7F01, 1'b0, 5'd11, 5'd0);
        checkOutput("lh2", bus.w_wd, 32'hFFFF80FF);
        tick();
        applyStimulus(1'b0, encI(6'h25, 5'd13), 32'h3014, 32'h0, 32'h0, 32'h0, 32'h80FF7F01, 1'b0, 5'd12, 5'd0);
        checkOutput("lhu0", bus.w_wd, 32'h00007F01);
        tick();

        applyStimulus(1'b0, {6'h03, 26'h0000c00}, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, encR(6'h09, 5'd7), 32'h3010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd31, 5'd0);
        checkOutput("jal31", bus.rd1, 32'h3008);
        tick();
        applyStimulus(1'b0, {6'h3f, 26'h0}, 32'h3020, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd7, 5'd0);
        checkOutput("jalr7", bus.rd1, 32'h3018);
        checkOutput("cond0_wa", {27'd0, bus.w_wa}, 32'd0);
        tick();
        applyStimulus(1'b0, {6'h3f, 26'h0}, 32'h3020, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd31, 5'd0);
        checkOutput("cond0_31", bus.rd1, 32'h3028);
        tick();
        applyStimulus(1'b0, encR(6'h20, 5'd8), 32'h3024, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd8, 5'd8);
        checkOutput("byp_rd1", bus.rd1, 32'hDEADBEEF);
        checkOutput("byp_rd2", bus.rd2, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, encI(6'h08, 5'd0), 32'h3028, 32'h0, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 5'd31);
        checkOutput("r0_wa", {27'd0, bus.w_wa}, 32'd0);
        checkOutput("cond1_31", bus.rd2, 32'h3028);
        tick();
        applyStimulus(1'b0, 32'd0, 32'h302c, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8);
        checkOutput("r0_stays", bus.rd1, 32'd0);
        checkOutput("rd8", bus.rd2, 32'hDEADBEEF);
        tick();

        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, encI(6'h0d, 5'(i)), 32'h4000, 32'h0, 32'h100 + i, 32'h0, 32'h0, 1'b0, 5'(i), 5'd0);
            tick();
        end
        applyStimulus(1'b1, encI(6'h23, 5'd9), 32'h4004, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 5'd9, 5'd1);
        checkOutput("rstlw_tv", {31'd0, bus.tr_valid}, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 32'd0, 32'h4008, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'(i), 5'(31 - i));
            checkOutput("clr_rd1", bus.rd1, 32'd0);
            checkOutput("clr_rd2", bus.rd2, 32'd0);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            rIns = $urandom;
            rOp  = 6'h00;
            case ($urandom_range(0, 13))
                0:  begin rOp = 6'h00; rIns[5:0] = aluFn[$urandom_range(0, 5)]; end
                1:  rOp = iOp[$urandom_range(0, 2)];
                2:  rOp = 6'h0f;
                3:  rOp = ldOp[$urandom_range(0, 4)];
                4:  rOp = 6'h03;
                5:  begin rOp = 6'h00; rIns[5:0] = 6'h09; end
                6:  begin rOp = 6'h00; rIns[5:0] = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12; end
                7:  rOp = 6'h3f;
                8:  rOp = 6'h2b;
                9:  rOp = 6'h04;
                10: rOp = 6'h02;
                11: begin rOp = 6'h00; rIns[5:0] = nwFn[$urandom_range(0, 2)]; end
                12: begin rOp = 6'h00; rIns = 32'd0; end
                default: rOp = 6'h3e;
            endcase
            rIns[31:26] = rOp;
            a1 = ($urandom_range(0, 1) == 0) ? rIns[15:11] : 5'($urandom);
            a2 = ($urandom_range(0, 1) == 0) ? rIns[20:16] : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a2 = 5'd31;
            applyStimulus(($urandom_range(0, 39) == 0), rIns, $urandom, $urandom, $urandom,
                          $urandom, $urandom, 1'($urandom), a1, a2);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline, consuming the M/W pipeline register outputs. Decodes the W-stage instruction, extends load data, selects the write-back value and destination, and writes the 32×32 general register file (GRF). Serves the two D-stage read ports with internal W→D bypass, and exports the W write address and data for E/M forwarding, plus a commit trace.

## Interface
- COND_OP, 6'h3f: opcode of the conditional-link instruction. When `con` = 1 it writes pc+8 to $31; otherwise it does not write.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- instr  in  32  W-stage instruction; 0 = nop
- pc  in  32  W-stage PC
- ext32  in  32  extended immediate; already shifted for lui
- ao  in  32  ALU result / memory address
- mduo  in  32  HI/LO read value
- rd  in  32  raw memory word
- con  in  1  condition flag of the conditional-link instruction
- ra1, ra2  in  5 each  D-stage read addresses
- rd1, rd2  out  32 each  D-stage read data, bypassed
- w_wa  out  5  effective write address; 0 = no write
- w_wd  out  32  write-back data
- tr_valid  out  1  write committed this cycle
- tr_pc, tr_reg, tr_data  out  32/5/32  commit trace

## Operation
- Decoded classes and their destination / data:
  - ALU R-type (add, sub, and, or, slt, sltu): rd field instr[15:11] ← ao
  - ALU I-type (addi, andi, ori): rt field instr[20:16] ← ao
  - lui: rt ← ext32
  - Loads (lw, lb, lbu, lh, lhu): rt ← extended load data
  - jal: 31 ← pc+8
  - jalr: rd field ← pc+8
  - mfhi, mflo: rd field ← mduo
  - COND_OP: 31 ← pc+8, only when con = 1
  - Everything else (stores, branches, j, jr, mult/div, mthi/mtlo, nop, unknown): no write, w_wa = 0.
- Load extension is little-endian on ao[1:0]:
  - lb/lbu byte select: 0→rd[7:0], 1→[15:8], 2→[23:16], 3→[31:24].
  - lh/lhu halfword select: ao[1]=0→rd[15:0], ao[1]=1→rd[31:16].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - ao[0] is ignored for halfwords; alignment is not checked.
- Write rule: we_eff = (w_wa != 0) & !reset. Register $0 always reads 0 and is never written.
- Read and bypass: rdN = 0 if raN = 0; w_wd if raN = w_wa and we_eff; otherwise the GRF entry.
- w_wa and w_wd are combinational from the inputs and stay valid during reset. Hazard logic qualifies them.
- Trace: tr_valid = we_eff, tr_pc = pc, tr_reg = w_wa, tr_data = w_wd.

## Timing
- Decode, extension, select and bypass are purely combinational. Inputs are settled just after each clk edge, because they come from the M/W register.
- The GRF write takes effect at the posedge where we_eff = 1. It is visible in the array the next cycle, and through the bypass in the same cycle.
- Reset: at the posedge with reset = 1, all 32 entries are cleared to 0 and no write happens.
  - After that edge: rd1 = rd2 = 0, tr_valid = 0.
  - w_wa and w_wd follow the inputs. With the M/W register also in reset (instr = 0), w_wa = 0 and w_wd = 0.
- Reset asserted mid-stream: any write pending at that edge is dropped and the clear wins.
- Simultaneous read and write of the same register: the bypass returns the new value. ra1 = ra2 = w_wa returns the new value on both ports.
- Latency from W input to architectural state: 1 clk edge.

## Structure
- Package `mips_pkg`:
  - opcode and funct localparams (SPECIAL, ADDI, ANDI, ORI, LUI, LW, LB, LBU, LH, LHU, JAL, funct JALR/MFHI/MFLO/ADD/SUB/AND/OR/SLT/SLTU)
  - wb-select enum {WB_NONE, WB_AO, WB_EXT, WB_LOAD, WB_PC8, WB_MDU}
  - dst-select enum {DST_RD, DST_RT, DST_31}
- Sub-module `grf`: a 32×32 array with synchronous clear, one write port and two async read ports, no bypass. Decode, load extension, mux and bypass live in wb_stage.

## Test plan
- Reset, then ori $5 with ao=0x1234 → tr_valid=1, tr_reg=5. The next cycle ra1=5 reads 0x00001234, and ra1=0 reads 0.
- lb with rd=0x80FF7F01:
  - ao[1:0]=3 → 0xFFFFFF80
  - lbu, ao[1:0]=3 → 0x00000080
  - lh, ao=2 → 0xFFFF80FF
  - lhu, ao=0 → 0x00007F01
- jal at pc=0x3000 → $31=0x3008. jalr rd=7 at pc=0x3010 → $7=0x3018.
- COND_OP at pc=0x3020: con=0 → w_wa=0, $31 unchanged. con=1 → $31=0x3028.
- Write $8=0xDEADBEEF with ra1=ra2=8 in the same cycle → both read 0xDEADBEEF before the edge. addiu-style write to $0 → w_wa=0, $0 stays 0.
- Fill $1..$31 with nonzero values, then assert reset while an lw to $9 is in W → all reads 0 afterwards, tr_valid=0 during reset.
